load_store_unit: RTL and testbench

//  Memory-access stage sitting between the core's execute logic and the data RAM port.

---
 rtl/load_store_unit_pkg.sv | 31 +++
 rtl/load_store_unit_if.sv | 44 ++++
 rtl/load_store_unit_lane_align.sv | 91 +++++++++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the FSM state encoding, the RV32I funct3 width/sign codes used for
// memory accesses, and a helper that tells whether a funct3 is a legal
// encoding for a load or for a store.
package load_store_unit_pkg;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_WAIT = 2'd1,
      LSU_RESP = 2'd2
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Stores only have signed-looking encodings (SB/SH/SW); the unsigned
   // variants exist for loads only.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = ~we;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-RAM bus of the load/store unit.
// Request side : i_req_valid/o_req_ready handshake with we, funct3, addr, wdata.
// Response side: o_resp_valid strobe with rdata and err.
// RAM side     : read strobe/address with returned word, write strobe with
//                byte enables, address and lane-shifted data.
// Modport slave is the unit itself; modport master is its environment
// (execute stage plus data RAM).
interface load_store_unit_if #(
   parameter int ADDR_WIDTH = 31,
   parameter int DATA_WIDTH = 31
);
   logic                  i_req_valid;
   logic                  o_req_ready;
   logic                  i_req_we;
   logic [2:0]            i_req_funct3;
   logic [ADDR_WIDTH:0]   i_req_addr;
   logic [DATA_WIDTH:0]   i_req_wdata;
   logic                  o_resp_valid;
   logic [DATA_WIDTH:0]   o_resp_rdata;
   logic                  o_resp_err;
   logic                  o_mem_read_req;
   logic [ADDR_WIDTH:0]   o_mem_read_addr;
   logic [DATA_WIDTH:0]   i_mem_read_data;
   logic                  o_mem_write_enable;
   logic [3:0]            o_mem_byte_enable;
   logic [ADDR_WIDTH:0]   o_mem_write_addr;
   logic [DATA_WIDTH:0]   o_mem_write_data;

   modport slave (
      input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
      input  i_mem_read_data,
      output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
      output o_mem_read_req, o_mem_read_addr,
      output o_mem_write_enable, o_mem_byte_enable, o_mem_write_addr, o_mem_write_data
   );

   modport master (
      output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
      output i_mem_read_data,
      input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
      input  o_mem_read_req, o_mem_read_addr,
      input  o_mem_write_enable, o_mem_byte_enable, o_mem_write_addr, o_mem_write_data
   );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane logic of the load/store unit.
// Ports:
//   req_we, req_funct3, req_addr_lo, req_wdata : live request being accepted
//   ld_funct3, ld_addr_lo, ld_word             : registered load info + RAM word
//   req_err    : illegal funct3 or misaligned address for the live request
//   store_be   : byte enables for the live store
//   store_data : store data replicated across the written lanes
//   load_data  : selected load lane, sign- or zero-extended
module load_store_unit_lane_align
   import load_store_unit_pkg::*;
(
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [1:0]  req_addr_lo,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] ld_word,
   output logic        req_err,
   output logic [3:0]  store_be,
   output logic [31:0] store_data,
   output logic [31:0] load_data
);

   logic        misaligned_s;
   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Alignment check: funct3[1:0] encodes the access size for both signednesses.
   always_comb begin
      misaligned_s = 1'b0;
      case (req_funct3[1:0])
         2'b00:   misaligned_s = 1'b0;
         2'b01:   misaligned_s = req_addr_lo[0];
         2'b10:   misaligned_s = |req_addr_lo;
         default: misaligned_s = 1'b0;
      endcase
      req_err = misaligned_s | ~f3_legal(req_we, req_funct3);
   end

   // Store lane generation: data is replicated so the enabled lanes carry it.
   always_comb begin
      store_be   = 4'b0000;
      store_data = 32'h0000_0000;
      case (req_funct3)
         F3_B: begin
            store_be   = 4'b0001 << req_addr_lo;
            store_data = {4{req_wdata[7:0]}};
         end
         F3_H: begin
            store_be   = req_addr_lo[1] ? 4'b1100 : 4'b0011;
            store_data = {2{req_wdata[15:0]}};
         end
         F3_W: begin
            store_be   = 4'b1111;
            store_data = req_wdata;
         end
         default: begin
            store_be   = 4'b0000;
            store_data = 32'h0000_0000;
         end
      endcase
   end

   // Load lane selection.
   always_comb begin
      byte_s = 8'h00;
      case (ld_addr_lo)
         2'd0:    byte_s = ld_word[7:0];
         2'd1:    byte_s = ld_word[15:8];
         2'd2:    byte_s = ld_word[23:16];
         2'd3:    byte_s = ld_word[31:24];
         default: byte_s = ld_word[7:0];
      endcase
      half_s = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
   end

   // Load extension by width and signedness.
   always_comb begin
      load_data = 32'h0000_0000;
      case (ld_funct3)
         F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
         F3_H:    load_data = {{16{half_s[15]}}, half_s};
         F3_W:    load_data = ld_word;
         F3_BU:   load_data = {24'h00_0000, byte_s};
         F3_HU:   load_data = {16'h0000, half_s};
         default: load_data = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage between execute and the data RAM port.
// Accepts one load/store at a time, drives word-aligned RAM accesses, waits
// READ_LATENCY cycles for load data and returns one registered response.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clk_en   : global stall; low freezes all state and blocks acceptance
//   bus      : request, response and data-RAM signals (slave side)
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_WIDTH   = 31,
   parameter int DATA_WIDTH   = 31,
   parameter int READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clk_en,
   load_store_unit_if.slave        bus
);

   localparam int CNT_W = $clog2(READ_LATENCY + 1);
   localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(READ_LATENCY);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   lsu_state_e            state_r;
   lsu_state_e            state_next_s;
   logic [CNT_W-1:0]      cnt_r;
   logic [CNT_W-1:0]      cnt_next_s;
   logic                  rd_req_r;
   logic [ADDR_WIDTH:0]   rd_addr_r;
   logic [2:0]            ld_f3_r;
   logic [1:0]            ld_lo_r;
   logic                  resp_valid_r;
   logic [DATA_WIDTH:0]   resp_rdata_r;
   logic                  resp_err_r;

   logic                  accept_s;
   logic                  store_s;
   logic                  load_s;
   logic                  wait_s;
   logic                  capture_s;
   logic                  err_s;
   logic [3:0]            store_be_s;
   logic [DATA_WIDTH:0]   store_data_s;
   logic [DATA_WIDTH:0]   load_data_s;
   logic [ADDR_WIDTH:0]   req_word_addr_s;

   load_store_unit_lane_align u_lane_align (
      .req_we      (bus.i_req_we),
      .req_funct3  (bus.i_req_funct3),
      .req_addr_lo (bus.i_req_addr[1:0]),
      .req_wdata   (bus.i_req_wdata),
      .ld_funct3   (ld_f3_r),
      .ld_addr_lo  (ld_lo_r),
      .ld_word     (bus.i_mem_read_data),
      .req_err     (err_s),
      .store_be    (store_be_s),
      .store_data  (store_data_s),
      .load_data   (load_data_s)
   );

   // Reset is folded into accept so no strobe escapes in a reset cycle.
   assign accept_s        = bus.i_req_valid & (state_r == LSU_IDLE) & clk_en & ~rst;
   assign store_s         = accept_s & bus.i_req_we & ~err_s;
   assign load_s          = accept_s & ~bus.i_req_we & ~err_s;
   assign wait_s          = (state_r == LSU_WAIT);
   assign capture_s       = wait_s & clk_en & ~rst & (cnt_r == LAT_CNT);
   assign req_word_addr_s = {bus.i_req_addr[ADDR_WIDTH:2], 2'b00};

   // Store strobes are combinational in the accept cycle; a load's read
   // request is combinational in that cycle and then held from registers.
   assign bus.o_req_ready        = (state_r == LSU_IDLE);
   assign bus.o_mem_write_enable = store_s;
   assign bus.o_mem_byte_enable  = store_s ? store_be_s : 4'b0000;
   assign bus.o_mem_write_addr   = req_word_addr_s;
   assign bus.o_mem_write_data   = store_s ? store_data_s : {(DATA_WIDTH+1){1'b0}};
   assign bus.o_mem_read_req     = load_s | (wait_s & rd_req_r & ~rst);
   assign bus.o_mem_read_addr    = wait_s ? rd_addr_r : req_word_addr_s;
   assign bus.o_resp_valid       = resp_valid_r;
   assign bus.o_resp_rdata       = resp_rdata_r;
   assign bus.o_resp_err         = resp_err_r;

   // Next-state and latency-counter logic; nothing advances while stalled.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      if (clk_en) begin
         case (state_r)
            LSU_IDLE: begin
               if (load_s) begin
                  state_next_s = LSU_WAIT;
                  cnt_next_s   = CNT_ONE;
               end else if (accept_s) begin
                  state_next_s = LSU_RESP;
               end else begin
                  state_next_s = LSU_IDLE;
               end
            end
            LSU_WAIT: begin
               if (cnt_r == LAT_CNT) begin
                  state_next_s = LSU_RESP;
               end else begin
                  cnt_next_s = cnt_r + CNT_ONE;
               end
            end
            LSU_RESP: state_next_s = LSU_IDLE;
            default:  state_next_s = LSU_IDLE;
         endcase
      end else begin
         state_next_s = state_r;
         cnt_next_s   = cnt_r;
      end
   end

   // State register, latency counter and response-valid flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= LSU_IDLE;
         cnt_r        <= '0;
         resp_valid_r <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         cnt_r        <= cnt_next_s;
         resp_valid_r <= (state_next_s == LSU_RESP);
      end
   end

   // Load context: read request/address and lane info captured at acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_req_r  <= 1'b0;
         rd_addr_r <= '0;
         ld_f3_r   <= 3'b000;
         ld_lo_r   <= 2'b00;
      end else if (load_s) begin
         rd_req_r  <= 1'b1;
         rd_addr_r <= req_word_addr_s;
         ld_f3_r   <= bus.i_req_funct3;
         ld_lo_r   <= bus.i_req_addr[1:0];
      end else if (capture_s) begin
         rd_req_r  <= 1'b0;
      end
   end

   // Response payload: zero data for stores/errors, extended lane for loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_rdata_r <= '0;
         resp_err_r   <= 1'b0;
      end else if (accept_s & ~load_s) begin
         resp_rdata_r <= '0;
         resp_err_r   <= err_s;
      end else if (capture_s) begin
         resp_rdata_r <= load_data_s;
         resp_err_r   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   localparam int RL_A = 1;

   logic clk;
   logic rst;
   logic clk_en;

   int n_checks = 0;
   int n_fail   = 0;

   load_store_unit_if #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) a_if ();
   load_store_unit_if #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) b_if ();

   load_store_unit #(.ADDR_WIDTH(31), .DATA_WIDTH(31), .READ_LATENCY(RL_A)) dut_a (
      .clk(clk), .rst(rst), .clk_en(clk_en), .bus(a_if.slave));

   load_store_unit #(.ADDR_WIDTH(31), .DATA_WIDTH(31), .READ_LATENCY(3)) dut_b (
      .clk(clk), .rst(rst), .clk_en(clk_en), .bus(b_if.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Data RAM contents as a pure function of the word address.
   function automatic logic [31:0] ram_word(input logic [31:0] addr);
      case (addr)
         32'h0000_0100: return 32'h8001_1234;
         32'h0000_0200: return 32'hCAFE_F00D;
         default:       return {addr[15:0] ^ 16'hA5C3, addr[15:0]};
      endcase
   endfunction

   // RAM for unit A: one-cycle read latency; garbage when not requested.
   always @(posedge clk) begin
      if (a_if.o_mem_read_req) a_if.i_mem_read_data <= ram_word(a_if.o_mem_read_addr);
      else                     a_if.i_mem_read_data <= 32'hDEAD_BEEF;
   end
   assign b_if.i_mem_read_data = 32'h8001_1234;

   // ---------------- reference model (unit A) ----------------
   function automatic logic exp_ok(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      int  bytes;
      logic legal;
      bytes = 1 << f3[1:0];
      if (we) legal = (f3 <= 3'd2);
      else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      return legal && ((addr % bytes) == 0);
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
      int bytes;
      bytes = 1 << f3[1:0];
      return 4'(((1 << bytes) - 1) << (addr % 4));
   endfunction

   function automatic logic [31:0] exp_sdata(input logic [2:0] f3, input logic [31:0] w);
      if (f3[1:0] == 2'd0)      return (w & 32'h0000_00FF) * 32'h0101_0101;
      else if (f3[1:0] == 2'd1) return (w & 32'h0000_FFFF) * 32'h0001_0001;
      else                      return w;
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] word);
      longint bytes, mask, v;
      bytes = 64'd1 << f3[1:0];
      if (bytes == 64'd4) return word;
      mask = (64'd1 << (8 * bytes)) - 64'd1;
      v = (longint'(word) >> (8 * lo)) & mask;
      if (!f3[2] && v > (mask >> 1)) v = v - (mask + 64'd1);
      return 32'(v);
   endfunction

   bit          m_on   = 1'b0;
   bit          m_idle = 1'b1;
   int          m_left = 0;
   bit          m_resp = 1'b0;
   logic [31:0] m_rdata = 32'h0;
   logic        m_err   = 1'b0;
   logic [31:0] m_addr  = 32'h0;
   logic [1:0]  m_lo    = 2'b00;
   logic [2:0]  m_f3    = 3'b000;

   always @(negedge clk) begin : model
      logic        acc, ok, w, rr;
      logic [31:0] wa;
      acc = a_if.i_req_valid && m_idle && clk_en && !rst;
      ok  = exp_ok(a_if.i_req_we, a_if.i_req_funct3, a_if.i_req_addr);
      wa  = a_if.i_req_addr & ~32'h0000_0003;
      if (m_on) begin
         chk("m_ready", 32'(a_if.o_req_ready), 32'(m_idle));
         chk("m_resp_valid", 32'(a_if.o_resp_valid), 32'(m_resp));
         if (m_resp) begin
            chk("m_resp_rdata", a_if.o_resp_rdata, m_rdata);
            chk("m_resp_err", 32'(a_if.o_resp_err), 32'(m_err));
         end
         w = acc && a_if.i_req_we && ok;
         chk("m_write_enable", 32'(a_if.o_mem_write_enable), 32'(w));
         if (w) begin
            chk("m_byte_enable", 32'(a_if.o_mem_byte_enable), 32'(exp_be(a_if.i_req_funct3, a_if.i_req_addr)));
            chk("m_write_addr", a_if.o_mem_write_addr, wa);
            chk("m_write_data", a_if.o_mem_write_data, exp_sdata(a_if.i_req_funct3, a_if.i_req_wdata));
         end
         if (rst) chk("m_be_in_reset", 32'(a_if.o_mem_byte_enable), 32'h0);
         rr = (acc && !a_if.i_req_we && ok) || (m_left > 0 && !rst);
         chk("m_read_req", 32'(a_if.o_mem_read_req), 32'(rr));
         if (rr) chk("m_read_addr", a_if.o_mem_read_addr, acc ? wa : m_addr);
      end
      if (rst) begin
         m_on = 1'b1; m_idle = 1'b1; m_left = 0; m_resp = 1'b0;
      end else if (m_on && clk_en) begin
         if (m_resp) begin
            m_resp = 1'b0; m_idle = 1'b1;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_resp  = 1'b1;
               m_err   = 1'b0;
               m_rdata = exp_load(m_f3, m_lo, ram_word(m_addr));
            end
         end else if (acc) begin
            m_idle = 1'b0;
            if (!ok) begin
               m_resp = 1'b1; m_rdata = 32'h0; m_err = 1'b1;
            end else if (a_if.i_req_we) begin
               m_resp = 1'b1; m_rdata = 32'h0; m_err = 1'b0;
            end else begin
               m_left = RL_A; m_addr = wa;
               m_lo = a_if.i_req_addr[1:0]; m_f3 = a_if.i_req_funct3;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic set_a(input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      a_if.i_req_valid = v; a_if.i_req_we = we; a_if.i_req_funct3 = f3;
      a_if.i_req_addr = addr; a_if.i_req_wdata = wd;
   endtask

   task automatic set_b(input logic v, input logic [2:0] f3, input logic [31:0] addr);
      b_if.i_req_valid = v; b_if.i_req_we = 1'b0; b_if.i_req_funct3 = f3;
      b_if.i_req_addr = addr; b_if.i_req_wdata = 32'h0;
   endtask

   typedef struct packed {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
   } vec_t;

   vec_t vecs [14];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic seen;
      int   n_we, n_acc, n_resp;
      logic [2:0]  alt_f3   [6];
      logic        alt_we   [6];
      logic [31:0] alt_addr [6];
      logic        alt_rdy  [6];

      rst = 1'b1; clk_en = 1'b1;
      set_a(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      set_b(1'b0, 3'b000, 32'h0);
      step();
      @(negedge clk);
      chk("rst_ready", 32'(a_if.o_req_ready), 32'h1);
      chk("rst_resp_valid", 32'(a_if.o_resp_valid), 32'h0);
      chk("rst_rdata", a_if.o_resp_rdata, 32'h0);
      chk("rst_err", 32'(a_if.o_resp_err), 32'h0);
      chk("rst_read_req", 32'(a_if.o_mem_read_req), 32'h0);
      chk("rst_write_enable", 32'(a_if.o_mem_write_enable), 32'h0);
      chk("rst_byte_enable", 32'(a_if.o_mem_byte_enable), 32'h0);
      step(); rst = 1'b0;
      @(negedge clk);

      // SB 0x103
      step(); set_a(1'b1, 1'b1, F3_B, 32'h0000_0103, 32'h0000_00AB);
      @(negedge clk);
      chk("sb_write_enable", 32'(a_if.o_mem_write_enable), 32'h1);
      chk("sb_be", 32'(a_if.o_mem_byte_enable), 32'h8);
      chk("sb_write_addr", a_if.o_mem_write_addr, 32'h0000_0100);
      chk("sb_write_data", a_if.o_mem_write_data, 32'hABAB_ABAB);
      step(); set_a(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      chk("sb_resp_valid", 32'(a_if.o_resp_valid), 32'h1);
      chk("sb_resp_err", 32'(a_if.o_resp_err), 32'h0);

      // LH / LHU 0x102, RAM word 0x80011234
      for (int k = 0; k < 2; k++) begin
         step(); set_a(1'b1, 1'b0, (k == 0) ? F3_H : F3_HU, 32'h0000_0102, 32'h0);
         @(negedge clk);
         chk("lh_read_req", 32'(a_if.o_mem_read_req), 32'h1);
         chk("lh_read_addr", a_if.o_mem_read_addr, 32'h0000_0100);
         step(); set_a(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
         @(negedge clk);
         chk("lh_no_resp_yet", 32'(a_if.o_resp_valid), 32'h0);
         step(); @(negedge clk);
         chk("lh_resp_valid", 32'(a_if.o_resp_valid), 32'h1);
         chk("lh_rdata", a_if.o_resp_rdata, (k == 0) ? 32'hFFFF_8001 : 32'h0000_8001);
      end

      // LW 0x101 misaligned
      step(); set_a(1'b1, 1'b0, F3_W, 32'h0000_0101, 32'h0);
      @(negedge clk);
      chk("lw_mis_read_req", 32'(a_if.o_mem_read_req), 32'h0);
      chk("lw_mis_write_enable", 32'(a_if.o_mem_write_enable), 32'h0);
      step(); set_a(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      chk("lw_mis_resp_valid", 32'(a_if.o_resp_valid), 32'h1);
      chk("lw_mis_err", 32'(a_if.o_resp_err), 32'h1);
      chk("lw_mis_rdata", a_if.o_resp_rdata, 32'h0);

      // LW 0x200 with clk_en low for 3 cycles in WAIT
      step(); set_a(1'b1, 1'b0, F3_W, 32'h0000_0200, 32'h0);
      @(negedge clk);
      for (int k = 1; k <= 4; k++) begin
         step(); set_a(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
         clk_en = (k == 4);
         @(negedge clk);
         chk("stall_read_req", 32'(a_if.o_mem_read_req), 32'h1);
         chk("stall_read_addr", a_if.o_mem_read_addr, 32'h0000_0200);
         chk("stall_no_resp", 32'(a_if.o_resp_valid), 32'h0);
      end
      step(); @(negedge clk);
      chk("stall_resp_valid", 32'(a_if.o_resp_valid), 32'h1);
      chk("stall_rdata", a_if.o_resp_rdata, 32'hCAFE_F00D);

      // Request offered while stalled, then accepted; stall during RESP
      step(); clk_en = 1'b0; set_a(1'b1, 1'b1, F3_W, 32'h0000_0300, 32'h1234_5678);
      @(negedge clk);
      chk("stalled_no_write", 32'(a_if.o_mem_write_enable), 32'h0);
      step(); clk_en = 1'b1; @(negedge clk);
      step(); clk_en = 1'b0; set_a(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      step(); @(negedge clk);
      chk("resp_held_in_stall", 32'(a_if.o_resp_valid), 32'h1);
      step(); clk_en = 1'b1; @(negedge clk);
      step(); @(negedge clk);
      chk("resp_released", 32'(a_if.o_resp_valid), 32'h0);

      // Model-checked vector table
      vecs[0]  = {1'b0, F3_B,  32'h0000_0100, 32'h0};
      vecs[1]  = {1'b0, F3_B,  32'h0000_0101, 32'h0};
      vecs[2]  = {1'b0, F3_B,  32'h0000_0102, 32'h0};
      vecs[3]  = {1'b0, F3_BU, 32'h0000_0103, 32'h0};
      vecs[4]  = {1'b0, F3_B,  32'h0000_0103, 32'h0};
      vecs[5]  = {1'b0, F3_H,  32'h0000_0100, 32'h0};
      vecs[6]  = {1'b1, F3_H,  32'h0000_0102, 32'h0000_BEEF};
      vecs[7]  = {1'b1, F3_B,  32'h0000_0101, 32'h0000_005A};
      vecs[8]  = {1'b1, F3_W,  32'h0000_0300, 32'hDEAD_BEEF};
      vecs[9]  = {1'b1, F3_H,  32'h0000_0103, 32'h0};
      vecs[10] = {1'b1, F3_BU, 32'h0000_0100, 32'h0};
      vecs[11] = {1'b0, 3'b011, 32'h0000_0100, 32'h0};
      vecs[12] = {1'b0, F3_W,  32'h0000_020C, 32'h0};
      vecs[13] = {1'b0, F3_HU, 32'h0000_0201, 32'h0};
      for (int i = 0; i < 14; i++) begin
         step(); set_a(1'b1, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd);
         step(); set_a(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
         repeat (3) step();
      end
      @(negedge clk);

      // Valid held for 6 cycles; the offered op changes after each acceptance
      alt_we   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      alt_f3   = '{F3_W, F3_W, F3_W, F3_W, F3_W, F3_W};
      alt_addr = '{32'h300, 32'h304, 32'h304, 32'h308, 32'h308, 32'h308};
      alt_rdy  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      n_we = 0; n_acc = 0; n_resp = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (k < 6) set_a(1'b1, alt_we[k], alt_f3[k], alt_addr[k], 32'h1122_3344 + 32'(k));
         else       set_a(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
         @(negedge clk);
         if (k < 6) chk("alt_ready", 32'(a_if.o_req_ready), 32'(alt_rdy[k]));
         if (a_if.i_req_valid && a_if.o_req_ready) n_acc++;
         if (a_if.o_mem_write_enable) n_we++;
         if (a_if.o_resp_valid) n_resp++;
      end
      chk("alt_accepts", 32'(n_acc), 32'd3);
      chk("alt_writes", 32'(n_we), 32'd2);
      chk("alt_resps", 32'(n_resp), 32'd3);

      // Unit B (latency 3): reset during WAIT drops the load
      step(); set_b(1'b1, F3_B, 32'h0000_0100);
      @(negedge clk);
      chk("b_accept_read_req", 32'(b_if.o_mem_read_req), 32'h1);
      step(); set_b(1'b0, F3_B, 32'h0); rst = 1'b1;
      @(negedge clk);
      chk("b_rst_read_req", 32'(b_if.o_mem_read_req), 32'h0);
      seen = b_if.o_resp_valid;
      step(); rst = 1'b0;
      @(negedge clk);
      chk("b_after_rst_ready", 32'(b_if.o_req_ready), 32'h1);
      chk("b_after_rst_read_req", 32'(b_if.o_mem_read_req), 32'h0);
      for (int k = 0; k < 6; k++) begin
         step(); @(negedge clk);
         seen = seen | b_if.o_resp_valid;
      end
      chk("b_no_resp_after_rst", 32'(seen), 32'h0);

      // Unit B: LB 0x103 completes at T+4
      step(); set_b(1'b1, F3_B, 32'h0000_0103);
      @(negedge clk);
      for (int k = 1; k <= 4; k++) begin
         step(); set_b(1'b0, F3_B, 32'h0);
         @(negedge clk);
         chk("b_lb_resp_valid", 32'(b_if.o_resp_valid), (k == 4) ? 32'h1 : 32'h0);
      end
      chk("b_lb_rdata", b_if.o_resp_rdata, 32'hFFFF_FF80);

      step(); step();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
